// File: rtl/imem_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_load_ctrl
// Brief    : Instruction-memory owner: byte-stream program loader, then a
//            checked fetch port for the pipeline, sharing one RAM port.
// Revision : 1.0 - initial release
// ============================================================================
module imem_load_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_words,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    localparam logic [31:0]   c_nop  = 32'h0000_0013;
    localparam logic [ADDR_W:0] c_one  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] c_full = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W:0]   r_total;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_lanes;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr_hold;
    logic              r_fv;
    logic              r_bad;
    logic              r_err;

    logic [ADDR_W:0]   w_cnt_p1;
    logic [ADDR_W:0]   w_target;
    logic              w_last_wr;
    logic              w_ld_ready;
    logic              w_accept;
    logic              w_start;
    logic              w_fetch;
    logic              w_bad_pc;
    logic [ADDR_W-1:0] w_mem_addr;

    // A latched count of zero stands for the full memory.
    assign w_cnt_p1   = {1'b0, r_word_cnt} + c_one;
    assign w_target   = (r_total == '0) ? c_full : r_total;
    assign w_last_wr  = r_we && (w_cnt_p1 == w_target);
    assign w_ld_ready = (r_state == S_LOAD) && !w_last_wr;
    assign w_accept   = ld_valid && w_ld_ready;
    assign w_start    = ld_start && (r_state != S_LOAD);
    assign w_fetch    = (r_state == S_RUN) && fetch_req && !w_start;
    assign w_bad_pc   = (fetch_pc[1:0] != 2'b00) || (fetch_pc[31:ADDR_W+2] != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_mem_addr  = r_addr_hold;
        case (r_state)
            S_IDLE:  if (ld_start)  w_state_nxt = S_LOAD;
            S_LOAD:  if (w_last_wr) w_state_nxt = S_RUN;
            S_RUN:   if (ld_start)  w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
        // A pending load write owns the port over any fetch address.
        if (r_we) begin
            w_mem_addr = r_word_cnt;
        end else if ((r_state == S_RUN) && fetch_req) begin
            w_mem_addr = fetch_pc[ADDR_W+1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_total     <= '0;
            r_word_cnt  <= '0;
            r_byte_idx  <= 2'd0;
            r_lanes     <= 24'd0;
            r_we        <= 1'b0;
            r_wdata     <= 32'd0;
            r_addr_hold <= '0;
            r_fv        <= 1'b0;
            r_bad       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr_hold <= w_mem_addr;
            r_we        <= 1'b0;
            r_fv        <= w_fetch;
            if (w_start) begin
                r_total    <= ld_words;
                r_word_cnt <= '0;
                r_byte_idx <= 2'd0;
            end else begin
                if (r_we) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
                if (w_accept) begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                    case (r_byte_idx)
                        2'd0:    r_lanes[7:0]   <= ld_data;
                        2'd1:    r_lanes[15:8]  <= ld_data;
                        2'd2:    r_lanes[23:16] <= ld_data;
                        default: begin
                            r_we    <= 1'b1;
                            r_wdata <= {ld_data, r_lanes};
                        end
                    endcase
                end
            end
            if (w_fetch) begin
                r_bad <= w_bad_pc;
            end
            if (w_start) begin
                r_err <= 1'b0;
            end else if (w_fetch && w_bad_pc) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ld_ready    = w_ld_ready;
    assign mem_addr    = w_mem_addr;
    assign mem_we      = r_we;
    assign mem_wdata   = r_wdata;
    assign fetch_valid = r_fv;
    assign fetch_instr = (r_fv && !r_bad) ? mem_rdata : c_nop;
    assign core_rst    = (r_state != S_RUN);
    assign done        = w_last_wr;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_load_ctrl
// Brief    : Scoreboard bench for imem_load_ctrl with a behavioural sync RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_load_ctrl;

    localparam int ADDR_W = 10;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ld_start = 1'b0;
    logic [ADDR_W:0]   ld_words = '0;
    logic              ld_valid = 1'b0;
    logic [7:0]        ld_data = 8'd0;
    logic              ld_ready;
    logic              fetch_req = 1'b0;
    logic [31:0]       fetch_pc = 32'd0;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              core_rst;
    logic              done;
    logic              err;

    imem_load_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_words(ld_words),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .core_rst(core_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct { int cyc; int addr; logic [31:0] data; logic dn; } wr_t;
    typedef struct { int cyc; logic [31:0] instr; logic er; } fr_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic er; } fvec_t;

    wr_t   wq[$];
    fr_t   fq[$];
    fvec_t ftab[9];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    int          bi;
    int          wc;
    int          last;
    logic [31:0] asmw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: every write and fetch response is matched to the cycle predicted at stimulus time.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_we", {31'd0, mem_we}, 32'd1);
            chk("wr_addr", {22'd0, mem_addr}, w.addr);
            chk("wr_data", mem_wdata, w.data);
            chk("wr_done", {31'd0, done}, {31'd0, w.dn});
        end else begin
            if (mem_we) chk("spurious_we", {31'd0, mem_we}, 32'd0);
            if (done)   chk("spurious_done", {31'd0, done}, 32'd0);
        end
        if (fq.size() > 0 && fq[0].cyc == cyc) begin
            fr_t f;
            f = fq.pop_front();
            chk("fetch_valid", {31'd0, fetch_valid}, 32'd1);
            chk("fetch_instr", fetch_instr, f.instr);
            chk("fetch_err", {31'd0, err}, {31'd0, f.er});
        end else if (fetch_valid) begin
            chk("spurious_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ld_start = 1'b0; ld_valid = 1'b0; fetch_req = 1'b0;
            ld_data = 8'($urandom);
        end
    endtask

    task automatic start_load(input int words);
        @(negedge clk);
        ld_start = 1'b1; ld_words = (ADDR_W+1)'(words);
        ld_valid = 1'b0; fetch_req = 1'b0;
        bi = 0; wc = 0;
        last = (words == 0) ? (1 << ADDR_W) - 1 : words - 1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ld_start = 1'b0; fetch_req = 1'b0;
        ld_valid = 1'b1; ld_data = b;
        #1;
        chk("ld_ready_load", {31'd0, ld_ready}, 32'd1);
        asmw[bi*8 +: 8] = b;
        if (bi == 3) begin
            wq.push_back('{cyc + 1, wc, asmw, (wc == last)});
            wc++;
        end
        bi = (bi + 1) % 4;
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8]);
    endtask

    // Write cycle of the final word: stray byte and fetch must be refused, then RUN.
    task automatic finish_load();
        @(negedge clk);
        ld_valid = 1'b1; ld_data = 8'hEE;
        fetch_req = 1'b1; fetch_pc = 32'd0;
        #1;
        chk("last_wr_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("last_wr_core_rst", {31'd0, core_rst}, 32'd1);
        chk("last_wr_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        ld_valid = 1'b0; fetch_req = 1'b0;
        #1;
        chk("run_core_rst", {31'd0, core_rst}, 32'd0);
        chk("run_ld_ready", {31'd0, ld_ready}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input logic er);
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b0;
        fetch_req = 1'b1; fetch_pc = pc;
        #1;
        chk("fetch_mem_addr", {22'd0, mem_addr}, {22'd0, pc[ADDR_W+1:2]});
        fq.push_back('{cyc + 1, instr, er});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'hDEAD_0000 | i;

        ftab[0] = '{32'h0000_0000, 32'h0040_81B3, 1'b0};
        ftab[1] = '{32'h0000_0004, 32'h4011_81B3, 1'b0};
        ftab[2] = '{32'h0000_0008, 32'h00A0_0093, 1'b0};
        ftab[3] = '{32'h0000_0006, NOP,          1'b1};
        ftab[4] = '{32'h0000_000C, 32'hDEAD_0003, 1'b1};
        ftab[5] = '{32'h0000_1000, NOP,          1'b1};
        ftab[6] = '{32'h0000_0FFC, 32'hDEAD_03FF, 1'b1};
        ftab[7] = '{32'h0000_0001, NOP,          1'b1};
        ftab[8] = '{32'h8000_0000, NOP,          1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_fetch_instr", fetch_instr, NOP);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        #1;
        chk("idle_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("idle_core_rst", {31'd0, core_rst}, 32'd1);

        // Two-word back-to-back load
        start_load(2);
        load_word(32'h0040_81B3);
        load_word(32'h4011_81B3);
        finish_load();

        fetch(32'h0, 32'h0040_81B3, 1'b0);
        fetch(32'h4, 32'h4011_81B3, 1'b0);
        fetch(32'h2, NOP, 1'b1);
        idle(2);
        #1;
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Reload from RUN with a fetch requested in the same cycle
        @(negedge clk);
        ld_start = 1'b1; ld_words = 11'd3;
        ld_valid = 1'b1; ld_data = 8'h77;
        fetch_req = 1'b1; fetch_pc = 32'h4;
        #1;
        chk("start_run_ld_ready", {31'd0, ld_ready}, 32'd0);
        bi = 0; wc = 0; last = 2;
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b0; fetch_req = 1'b0;
        #1;
        chk("reload_fetch_dropped", {31'd0, fetch_valid}, 32'd0);
        chk("reload_core_rst", {31'd0, core_rst}, 32'd1);
        chk("reload_err_clr", {31'd0, err}, 32'd0);

        // Stalled three-word load: gaps of 1..3 cycles between bytes
        begin
            logic [31:0] words [3];
            words[0] = 32'h0040_81B3;
            words[1] = 32'h4011_81B3;
            words[2] = 32'h00A0_0093;
            for (int j = 0; j < 12; j++) begin
                send_byte(words[j/4][(j%4)*8 +: 8]);
                if (j < 11) idle(1 + (j % 3));
            end
        end
        finish_load();

        for (int i = 0; i < 9; i++) fetch(ftab[i].pc, ftab[i].instr, ftab[i].er);
        idle(3);

        // Reset in the middle of a word, then a clean reload
        start_load(1);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rst = 1'b1; ld_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        idle(1);
        start_load(1);
        load_word(32'hCAFE_F00D);
        finish_load();
        fetch(32'h0, 32'hCAFE_F00D, 1'b0);
        fetch(32'h4, 32'h4011_81B3, 1'b0);
        idle(2);

        // Count 0 fills the entire memory
        start_load(0);
        for (int i = 0; i < (1 << ADDR_W); i++) load_word(32'hA500_0000 + i);
        finish_load();
        fetch(32'h0000_0FFC, 32'hA500_03FF, 1'b0);
        fetch(32'h0000_0000, 32'hA500_0000, 1'b0);
        idle(3);

        chk("wq_drained", wq.size(), 32'd0);
        chk("fq_drained", fq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
